// File: rtl/rib_master_arbiter.sv
// Registered four-master RIB arbiter: fixed debug priority (m3 > m2), round-robin core masters, owner lock.
// Optional debug starvation guard is built when RIB_ARB_STARVE_GUARD_EN is defined.
module rib_master_arbiter #(
    parameter int MAX_HOLD = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req_i,
    input  logic [3:0] lock_i,
    output logic [3:0] grant_o,
    output logic [1:0] grant_idx_o,
    output logic       grant_valid_o,
    output logic       hold_flag_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN   = 2'd1,
        FORCE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] grant_q, grant_d;
    logic [1:0] grant_idx_q, grant_idx_d;
    logic       grant_valid_q, grant_valid_d;
    logic       rr_last_q, rr_last_d;
    logic       core_pick_s;
    logic       owner_locked_s;
    logic       expire_s;

    function automatic logic [1:0] encode_grant(input logic [3:0] onehot);
        logic [1:0] idx;
        case (onehot)
            4'b0001: idx = 2'd0;
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

`ifdef RIB_ARB_STARVE_GUARD_EN
    localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

    logic [7:0] cnt_q, cnt_d;
    logic       debug_wait_s;

    // Count cycles in which a debug owner stalls a pending core request; expiry includes the current cycle.
    always_comb begin
        debug_wait_s = (|grant_q[3:2]) && (|req_i[1:0]);
        expire_s     = debug_wait_s && (cnt_q == (HOLD_MAX - 8'd1));
        if (!debug_wait_s || expire_s) begin
            cnt_d = 8'd0;
        end else if (cnt_q == HOLD_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_max_hold_s;
    assign unused_max_hold_s = ^MAX_HOLD;
    assign expire_s          = 1'b0;
`endif

    // Only a master that stays in OWN may retain the bus; a FORCE slot always re-arbitrates.
    assign core_pick_s    = (req_i[0] && req_i[1]) ? ~rr_last_q : req_i[1];
    assign owner_locked_s = (state_q == OWN) && (|(grant_q & req_i & lock_i));

    // Next grant, state and round-robin pointer.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_last_d = rr_last_q;
        if (expire_s) begin
            grant_d = {2'b00, core_pick_s, ~core_pick_s};
            state_d = FORCE;
        end else if (owner_locked_s) begin
            state_d = OWN;
        end else if (req_i[3]) begin
            grant_d = 4'b1000;
            state_d = OWN;
        end else if (req_i[2]) begin
            grant_d = 4'b0100;
            state_d = OWN;
        end else if (|req_i[1:0]) begin
            grant_d = {2'b00, core_pick_s, ~core_pick_s};
            state_d = OWN;
        end else begin
            grant_d = 4'b0000;
            state_d = IDLE;
        end
        if (grant_d[0]) begin
            rr_last_d = 1'b0;
        end else if (grant_d[1]) begin
            rr_last_d = 1'b1;
        end else begin
            rr_last_d = rr_last_q;
        end
        grant_idx_d   = encode_grant(grant_d);
        grant_valid_d = |grant_d;
    end

    // Arbiter state registers; rr_last resets to 1 so m0 wins the first core tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            grant_q       <= 4'b0000;
            grant_idx_q   <= 2'd0;
            grant_valid_q <= 1'b0;
            rr_last_q     <= 1'b1;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            grant_idx_q   <= grant_idx_d;
            grant_valid_q <= grant_valid_d;
            rr_last_q     <= rr_last_d;
        end
    end

    assign grant_o       = grant_q;
    assign grant_idx_o   = grant_idx_q;
    assign grant_valid_o = grant_valid_q;
    assign hold_flag_o   = ~rst & (|req_i[1:0]) & ~(|grant_q[1:0]);

endmodule

// File: tb/tb_rib_master_arbiter.sv
// Randomized and directed bench for rib_master_arbiter against a cycle-level behavioural model.
module tb_rib_master_arbiter;

    localparam int MH = 4;
`ifdef RIB_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [3:0] req_i;
    logic [3:0] lock_i;
    logic [3:0] grant_o;
    logic [1:0] grant_idx_o;
    logic       grant_valid_o;
    logic       hold_flag_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: owner index (-1 idle), last granted core master, debug wait cycles, previous edge was a forced slot
    int m_owner = -1;
    int m_last  = 1;
    int m_wait  = 0;
    bit m_force = 1'b0;

    rib_master_arbiter #(.MAX_HOLD(MH)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_i        (req_i),
        .lock_i       (lock_i),
        .grant_o      (grant_o),
        .grant_idx_o  (grant_idx_o),
        .grant_valid_o(grant_valid_o),
        .hold_flag_o  (hold_flag_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic logic [3:0] exp_grant();
        return (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
    endfunction

    function automatic logic exp_hold();
        logic [3:0] g;
        g = exp_grant();
        return !rst && (req_i[1:0] != 2'b00) && (g[1:0] == 2'b00);
    endfunction

    task automatic model_update(input logic [3:0] r, input logic [3:0] l, input logic rs);
        int  prev;
        int  pick;
        bit  core_req;
        if (rs) begin
            m_owner = -1;
            m_last  = 1;
            m_wait  = 0;
            m_force = 1'b0;
            return;
        end
        prev     = m_owner;
        core_req = r[0] || r[1];
        pick     = (r[0] && r[1]) ? (1 - m_last) : (r[0] ? 0 : 1);
        if (GUARD && prev >= 2 && core_req && (m_wait + 1 == MH)) begin
            m_owner = pick;
            m_wait  = 0;
            m_force = 1'b1;
        end else begin
            m_wait = (prev >= 2 && core_req) ? m_wait + 1 : 0;
            if (!m_force && prev >= 0 && r[prev] && l[prev]) m_owner = prev;
            else if (r[3])                                   m_owner = 3;
            else if (r[2])                                   m_owner = 2;
            else if (core_req)                               m_owner = pick;
            else                                             m_owner = -1;
            m_force = 1'b0;
        end
        if (m_owner == 0 || m_owner == 1) m_last = m_owner;
    endtask

    task automatic compare_all();
        logic [3:0] g;
        g = exp_grant();
        check_eq("grant", grant_o, g);
        check_eq("grant_idx", grant_idx_o, (m_owner < 0) ? 0 : m_owner);
        check_eq("grant_valid", grant_valid_o, g != 4'b0000);
        check_eq("hold_flag", hold_flag_o, exp_hold());
    endtask

    // Apply inputs for one cycle, check the combinational hold flag, then the registered result.
    task automatic step(input logic [3:0] r, input logic [3:0] l, input logic rs);
        req_i  = r;
        lock_i = l;
        rst    = rs;
        #1;
        check_eq("hold_pre_edge", hold_flag_o, exp_hold());
        @(posedge clk);
        model_update(r, l, rs);
        #1;
        compare_all();
    endtask

    initial begin
        int m1_slots;
        req_i  = 4'b0000;
        lock_i = 4'b0000;
        rst    = 1'b1;

        // Reset with core requests present: outputs and hold flag stay 0.
        step(4'b0011, 4'b0000, 1'b1);
        step(4'b0011, 4'b0000, 1'b1);
        check_eq("reset_grant", grant_o, 4'b0000);

        // Core round-robin: 0001, 0010, 0001, 0010.
        step(4'b0011, 4'b0000, 1'b0);
        check_eq("rr_first_m0", grant_o, 4'b0001);
        for (int i = 0; i < 3; i++) step(4'b0011, 4'b0000, 1'b0);

        // All request: m3, then m2 with no idle gap.
        step(4'b1111, 4'b0000, 1'b0);
        check_eq("all_req_m3", grant_o, 4'b1000);
        step(4'b0111, 4'b0000, 1'b0);
        check_eq("handover_m2", grant_o, 4'b0100);
        step(4'b0000, 4'b0000, 1'b0);

        // Locked m0 holds off m3 until it releases.
        step(4'b0001, 4'b0001, 1'b0);
        for (int i = 0; i < 3; i++) step(4'b1001, 4'b0001, 1'b0);
        check_eq("lock_keeps_m0", grant_o, 4'b0001);
        step(4'b1000, 4'b0001, 1'b0);
        check_eq("release_to_m3", grant_o, 4'b1000);

        // Locked m2 with m1 waiting: guard pattern or indefinite hold.
        step(4'b0000, 4'b0000, 1'b0);
        m1_slots = 0;
        for (int i = 0; i < 100; i++) begin
            step(4'b0110, 4'b0100, 1'b0);
            if (grant_o == 4'b0010) m1_slots++;
        end
        check_eq("starve_m1_slots", m1_slots, GUARD ? 20 : 0);

        // Reset while m3 is locked, then m0 wins first core tie.
        step(4'b1000, 4'b1000, 1'b0);
        step(4'b1011, 4'b1000, 1'b1);
        check_eq("mid_reset_clear", grant_o, 4'b0000);
        step(4'b0011, 4'b0000, 1'b0);
        check_eq("post_reset_m0", grant_o, 4'b0001);

        // Randomized traffic with occasional reset.
        for (int i = 0; i < 800; i++) begin
            logic [3:0] r;
            logic [3:0] l;
            r = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) r[3:2] = 2'b00;
            l = 4'($urandom_range(0, 15));
            step(r, l, $urandom_range(0, 63) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
